// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the push-button event decoder: FSM state encoding
// and default timing constants for the 50 MHz board clock.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } btn_state_e;

  localparam int LONG_1S_50M      = 50_000_000;
  localparam int DCLICK_250MS_50M = 12_500_000;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Single-register edge detector for an already-synchronous level input.
// Reusable for any debounced switch on the board.
module edge_detect (
  input  logic clk_i,
  input  logic lvl_i,
  output logic rise_o,
  output logic fall_o
);

  logic lvl_q;

  // Unconditional load: during reset this tracks the input, so a level held
  // through reset release does not look like a fresh edge.
  always_ff @(posedge clk_i) begin
    lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;
  assign fall_o = ~lvl_i & lvl_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short-click/
// double-click/long-press pulses. All outputs are registered.
import button_event_decoder_pkg::*;

module button_event_decoder #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LONG_CYCLES   = LONG_1S_50M,
  parameter int DCLICK_CYCLES = DCLICK_250MS_50M,
  parameter int CNT_W         = 26
) (
  input  logic clk50M,
  input  logic reset,
  input  logic pressed_state,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic btn_s, rise_s, fall_s;
  logic [CNT_W-1:0] cnt_inc_s;

  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic held_q;
  logic press_q, press_d;
  logic release_q, release_d;
  logic short_q, short_d;
  logic double_q, double_d;
  logic long_q, long_d;

  assign btn_s = pressed_state ^ ACTIVE_LOW;

  edge_detect u_edge (
    .clk_i  (clk50M),
    .lvl_i  (btn_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // State, duration counter and registered event outputs.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= btn_s;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  // Next-state and event decode; falls take priority over the long-press
  // compare, and a second press wins over the double-click window timeout.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          press_d = 1'b1;
          state_d = PRESS1;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS1: begin
        if (fall_s) begin
          release_d = 1'b1;
          state_d   = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end else begin
          state_d = PRESS1;
        end
      end
      LONG: begin
        if (fall_s) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = LONG;
        end
      end
      WAIT2: begin
        if (rise_s) begin
          press_d  = 1'b1;
          double_d = 1'b1;
          state_d  = PRESS2;
        end else if (cnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT2;
        end
      end
      PRESS2: begin
        if (fall_s) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = PRESS2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign double_click  = double_q;
  assign long_press    = long_q;

endmodule
